shift_exec_stage: RTL and testbench

//  Two-stage pipelined shift/rotate execute unit for the RV32I core (+ Zbb ROL/ROR/RORI).

---
 rtl/shift_exec_stage.sv | 170 +++++++++++++++++
 tb/tb_shift_exec_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_stage.sv
// Two-stage valid/ready shift/rotate execute unit (RV32I shifts + Zbb rotates); result 2 cycles after accept.
// Stage 1 decodes and registers operands, stage 2 registers the barrel_masker result; stalls propagate back via in_ready.

module barrel_masker #(
    parameter int Width    = 32,
    parameter int AmtWidth = $clog2(Width)
) (
    input  logic [Width-1:0]    value,
    input  logic [AmtWidth-1:0] amount,
    input  logic                left1_right0,
    input  logic                shift1_rotate0,
    input  logic                arith1_logic0,
    input  logic                sign,
    output logic [Width-1:0]    result
);
    logic [2*Width-1:0] dbl_left;
    logic [2*Width-1:0] dbl_right;
    logic [Width-1:0]   rotated;
    logic [Width-1:0]   left_mask;
    logic [Width-1:0]   right_mask;
    logic [Width-1:0]   fill;

    // Rotate first, then mask away the wrapped-in bits for true shifts.
    always_comb begin
        dbl_left   = {value, value} << amount;
        dbl_right  = {value, value} >> amount;
        rotated    = left1_right0 ? dbl_left[2*Width-1:Width] : dbl_right[Width-1:0];
        left_mask  = {Width{1'b1}} << amount;
        right_mask = {Width{1'b1}} >> amount;
        fill       = {Width{arith1_logic0 & sign}} & ~right_mask;
        result     = rotated;
        if (shift1_rotate0) begin
            if (left1_right0) begin
                result = rotated & left_mask;
            end else begin
                result = (rotated & right_mask) | fill;
            end
        end
    end
endmodule

module shift_exec_stage #(
    parameter int BitWidth = 32,
    parameter int TagWidth = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_funct3,
    input  logic [6:0]          in_funct7,
    input  logic                in_is_imm,
    input  logic [BitWidth-1:0] in_rs1,
    input  logic [BitWidth-1:0] in_rs2,
    input  logic [TagWidth-1:0] in_rd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BitWidth-1:0] out_result,
    output logic [TagWidth-1:0] out_rd,
    output logic                out_illegal
);
    localparam int AmtWidth = $clog2(BitWidth);

    logic                s1_valid;
    logic [BitWidth-1:0] s1_rs1;
    logic [AmtWidth-1:0] s1_amount;
    logic                s1_left;
    logic                s1_shift;
    logic                s1_arith;
    logic                s1_sign;
    logic                s1_illegal;
    logic [TagWidth-1:0] s1_rd;

    logic                s1_load;
    logic                s2_load;
    logic                dec_left;
    logic                dec_shift;
    logic                dec_arith;
    logic                dec_illegal;
    logic [BitWidth-1:0] bm_result;
    logic                unused_rs2_high;

    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign s1_load  = in_valid && in_ready;

    // Upper rs2 bits are the rest of the immediate / register value; only the amount matters.
    assign unused_rs2_high = ^in_rs2[BitWidth-1:AmtWidth];

    always_comb begin
        dec_left    = 1'b0;
        dec_shift   = 1'b1;
        dec_arith   = 1'b0;
        dec_illegal = 1'b0;
        case (in_funct3)
            3'b001: begin
                dec_left = 1'b1;
                if (in_funct7 == 7'b0110000 && !in_is_imm) begin
                    dec_shift = 1'b0;
                end else if (in_funct7 != 7'b0000000) begin
                    dec_illegal = 1'b1;
                end
            end
            3'b101: begin
                case (in_funct7)
                    7'b0000000: dec_arith = 1'b0;
                    7'b0100000: dec_arith = 1'b1;
                    7'b0110000: dec_shift = 1'b0;
                    default:    dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_rs1     <= '0;
            s1_amount  <= '0;
            s1_left    <= 1'b0;
            s1_shift   <= 1'b0;
            s1_arith   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_illegal <= 1'b0;
            s1_rd      <= '0;
        end else if (s1_load) begin
            s1_valid   <= 1'b1;
            s1_rs1     <= in_rs1;
            s1_amount  <= in_rs2[AmtWidth-1:0];
            s1_left    <= dec_left;
            s1_shift   <= dec_shift;
            s1_arith   <= dec_arith;
            s1_sign    <= in_rs1[BitWidth-1];
            s1_illegal <= dec_illegal;
            s1_rd      <= in_rd;
        end else if (s2_load) begin
            s1_valid   <= 1'b0;
        end
    end

    barrel_masker #(
        .Width    (BitWidth),
        .AmtWidth (AmtWidth)
    ) u_barrel_masker (
        .value          (s1_rs1),
        .amount         (s1_amount),
        .left1_right0   (s1_left),
        .shift1_rotate0 (s1_shift),
        .arith1_logic0  (s1_arith),
        .sign           (s1_sign),
        .result         (bm_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
        end else if (s2_load) begin
            out_valid   <= 1'b1;
            out_result  <= s1_illegal ? '0 : bm_result;
            out_rd      <= s1_rd;
            out_illegal <= s1_illegal;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shift_exec_stage.sv
// Random and directed ops against a queue-based reference model of the shift/rotate pipeline.
module tb_shift_exec_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic        in_is_imm;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    typedef struct {
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
    } op_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
        int          acc;
        logic        lit_en;
        logic [31:0] lit;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   started = 0;

    shift_exec_stage #(.BitWidth(32), .TagWidth(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_funct3   (in_funct3),
        .in_funct7   (in_funct7),
        .in_is_imm   (in_is_imm),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] ref_op(input op_t op);
        int          a;
        logic [31:0] r;
        a = int'(op.rs2 % 32);
        if (op.f3 == 3'd1 && op.f7 == 7'h00) begin
            r = op.rs1 << a;
        end else if (op.f3 == 3'd1 && op.f7 == 7'h30 && !op.imm) begin
            r = (op.rs1 << a) | (op.rs1 >> (32 - a));
        end else if (op.f3 == 3'd5 && op.f7 == 7'h00) begin
            r = op.rs1 >> a;
        end else if (op.f3 == 3'd5 && op.f7 == 7'h20) begin
            r = 32'($signed(op.rs1) >>> a);
        end else if (op.f3 == 3'd5 && op.f7 == 7'h30) begin
            r = (op.rs1 >> a) | (op.rs1 << (32 - a));
        end else begin
            return {1'b1, 32'h0};
        end
        return {1'b0, r};
    endfunction

    function automatic op_t mk(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                               input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] rd);
        op_t o;
        o.f3 = f3; o.f7 = f7; o.imm = imm; o.rs1 = rs1; o.rs2 = rs2; o.rd = rd;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        case ($urandom_range(0, 7))
            0:       o.f3 = 3'($urandom);
            1, 2, 3: o.f3 = 3'd1;
            default: o.f3 = 3'd5;
        endcase
        case ($urandom_range(0, 6))
            0, 1, 6: o.f7 = 7'h00;
            2:       o.f7 = 7'h20;
            3, 4:    o.f7 = 7'h30;
            default: o.f7 = 7'($urandom);
        endcase
        o.imm = 1'($urandom);
        o.rs1 = $urandom;
        case ($urandom_range(0, 3))
            0:       o.rs2 = $urandom & 32'hFFFF_FFE0;
            1:       o.rs2 = 32'($urandom_range(0, 31));
            default: o.rs2 = $urandom;
        endcase
        o.rd = 5'($urandom);
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive at negedge, compare against the model, then record handshakes.
    task automatic cycle(input logic r, input logic v, input op_t op, input logic ordy,
                         input logic lit_en, input logic [31:0] lit, output logic took);
        exp_t        e;
        logic        exp_ov;
        logic        exp_ir;
        logic [32:0] m;
        @(negedge clk);
        rst = r; in_valid = v; in_funct3 = op.f3; in_funct7 = op.f7; in_is_imm = op.imm;
        in_rs1 = op.rs1; in_rs2 = op.rs2; in_rd = op.rd; out_ready = ordy;
        #1;
        exp_ov = (q.size() > 0) && (q[0].acc < cyc);
        exp_ir = (q.size() < 2) || ordy;
        took = 1'b0;
        if (started) begin
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            chk("in_ready", 32'(in_ready), 32'(exp_ir));
            if (exp_ov) begin
                chk("out_result", out_result, q[0].res);
                chk("out_rd", 32'(out_rd), 32'(q[0].rd));
                chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
                if (q[0].lit_en) chk("lit_result", out_result, q[0].lit);
            end
        end
        if (!r) begin
            if (exp_ov && ordy) void'(q.pop_front());
            if (v && exp_ir) begin
                m = ref_op(op);
                e.res = m[31:0]; e.ill = m[32]; e.rd = op.rd; e.acc = cyc + 1;
                e.lit_en = lit_en; e.lit = lit;
                q.push_back(e);
                took = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        if (r) begin
            q.delete();
            started = 1;
        end
    endtask

    task automatic idle(input logic ordy, input int n);
        logic t;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), ordy, 1'b0, 0, t);
    endtask

    task automatic send(input op_t op, input logic ordy, input logic [31:0] lit);
        logic t;
        cycle(1'b0, 1'b1, op, ordy, 1'b1, lit, t);
        if (!t) begin
            fails++; tests++;
            $display("FAIL send_accept at cycle %0d: got in_ready 0, expected 1", cyc);
        end
    endtask

    initial begin
        logic t;
        op_t  cur;
        int   accepted;
        int   budget;

        // Reset with in_valid held high: nothing may enter.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, mk(3'd1, 0, 0, 32'h5, 32'h1, 5'd3), 1'b1, 1'b0, 0, t);
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);

        send(mk(3'd5, 7'h20, 1'b0, 32'h8000_00F0, 32'd4, 5'd1), 1'b1, 32'hF800_000F);
        send(mk(3'd5, 7'h00, 1'b1, 32'h8000_00F0, 32'd4, 5'd2), 1'b1, 32'h0800_000F);
        send(mk(3'd1, 7'h00, 1'b0, 32'h1, 32'h21, 5'd3), 1'b1, 32'h2);
        send(mk(3'd5, 7'h30, 1'b0, 32'h1, 32'h1, 5'd4), 1'b1, 32'h8000_0000);
        send(mk(3'd1, 7'h30, 1'b0, 32'h8000_0000, 32'h1, 5'd5), 1'b1, 32'h1);
        send(mk(3'd0, 7'h00, 1'b0, 32'hDEAD_BEEF, 32'h3, 5'd6), 1'b1, 32'h0);
        send(mk(3'd1, 7'h30, 1'b1, 32'hDEAD_BEEF, 32'h3, 5'd7), 1'b1, 32'h0);
        send(mk(3'd5, 7'h20, 1'b1, 32'hCAFE_F00D, 32'h20, 5'd8), 1'b1, 32'hCAFE_F00D);
        idle(1'b1, 3);

        // Eight back-to-back ops, then three stalled cycles.
        for (int i = 0; i < 8; i++) begin
            cur = rand_op();
            send(cur, 1'b1, ref_op(cur) & 33'h0_FFFF_FFFF);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, rand_op(), 1'b0, 1'b0, 0, t);
        idle(1'b1, 4);

        // Reset with both stages full, then a clean op.
        send(mk(3'd1, 7'h00, 1'b0, 32'h3, 32'h4, 5'd9), 1'b0, 32'h30);
        send(mk(3'd1, 7'h00, 1'b0, 32'h3, 32'h5, 5'd10), 1'b0, 32'h60);
        idle(1'b0, 1);
        cycle(1'b1, 1'b1, mk(3'd1, 0, 0, 32'h1, 32'h1, 5'd11), 1'b0, 1'b0, 0, t);
        idle(1'b1, 1);
        send(mk(3'd5, 7'h00, 1'b0, 32'hF000_0000, 32'd28, 5'd12), 1'b1, 32'hF);
        idle(1'b1, 3);

        accepted = 0;
        budget = 0;
        cur = rand_op();
        while (accepted < 10000 && budget < 40000) begin
            cycle(1'b0, 1'($urandom_range(0, 4) != 0), cur, 1'($urandom_range(0, 3) != 0), 1'b0, 0, t);
            if (t) begin
                accepted++;
                cur = rand_op();
            end
            budget++;
        end
        if (accepted < 10000) begin
            tests++; fails++;
            $display("FAIL random_budget: got %0d accepted ops, expected 10000", accepted);
        end

        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            idle(1'b1, 1);
            budget++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
